ifetch_ctrl: RTL
================

IFETCH_CTRL -- requirements
Module: ifetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch byte address after reset.
REQ-002 SHALL have parameter ADDR_W, default 10, instruction-memory word-address width.
REQ-003 SHALL have one clock; reset is asynchronous and active-low, ports named clk and rst_n.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 mem_req  output  1  fetch request to instruction memory.
REQ-007 mem_addr  output  ADDR_W  word address, equal to fetch_pc[ADDR_W+1:2].
REQ-008 mem_valid  input  1  memory response valid, exactly one cycle after mem_req.
REQ-009 mem_instr  input  32  memory response word.
REQ-010 stall  input  1  decode not ready; head entry not consumed this cycle.
REQ-011 redirect  input  1  branch/jump taken; flush and refetch.
REQ-012 redirect_pc  input  32  new fetch byte address.
REQ-013 if_valid  output  1  if_instr/if_pc hold a valid instruction.
REQ-014 if_instr  output  32  instruction at buffer head.
REQ-015 if_pc  output  32  byte PC of if_instr.

Function
REQ-016 SHALL keep a 32-bit fetch_pc, a 2-entry instruction FIFO ({pc,instr} pairs), and an inflight flag set the cycle mem_req=1.
REQ-017 FSM states: WAIT (first cycle after reset release), RUN, FULL, FLUSH.
REQ-018 WAIT -> RUN unconditionally after one cycle, with mem_req=0 in WAIT.
REQ-019 In RUN, mem_req SHALL be 1 when fifo_count + inflight < 2 and redirect=0; each issued request advances fetch_pc by 4 (32-bit wrap, mem_addr wraps modulo 2^ADDR_W).
REQ-020 RUN -> FULL when fifo_count + inflight = 2 at the end of the cycle; FULL -> RUN when the head is consumed; mem_req=0 in FULL.
REQ-021 A mem_valid response SHALL be written to the FIFO tail with the pc of its issuing request; overflow is impossible by credit rule and SHALL never occur.
REQ-022 Head SHALL be consumed (popped) on a cycle with if_valid=1 and stall=0; simultaneous push and pop SHALL keep count unchanged.
REQ-023 if_valid = (fifo_count != 0); if_instr/if_pc SHALL be held stable while stall=1.
REQ-024 Latency: request issued in cycle N -> if_valid in cycle N+2 when FIFO empty.
REQ-025 redirect=1 in any state (except WAIT) SHALL enter FLUSH: clear FIFO, discard that cycle's mem_valid response, set fetch_pc = {redirect_pc[31:2],2'b00}, drive mem_req=0, if_valid=0 next cycle.
REQ-026 FLUSH -> RUN after one cycle; first request in RUN uses redirected pc.
REQ-027 redirect in WAIT SHALL be latched into fetch_pc, and the state stays WAIT for its single cycle.
REQ-028 redirect SHALL take priority over stall and over a same-cycle pop.
REQ-029 redirect_pc[1:0] SHALL be ignored.

Reset
REQ-030 rst_n=0 SHALL immediately force: state=WAIT, fetch_pc=RESET_PC, FIFO empty, inflight=0, mem_req=0, mem_addr=RESET_PC[ADDR_W+1:2], if_valid=0, if_instr=32'h0000_0013, if_pc=RESET_PC.
REQ-031 Reset mid-operation SHALL discard all buffered and in-flight instructions; a mem_valid arriving after reset release before any request SHALL be ignored.

Configuration
REQ-032 Macro IFETCH_PERF_EN defined SHALL add outputs perf_fetched (32-bit, counts FIFO pops) and perf_stall (32-bit, counts cycles with if_valid=1 and stall=1), both reset to 0 and wrapping at 2^32.
REQ-033 Without IFETCH_PERF_EN, those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-034 Reset release, stall=0, RESET_PC=0, ROM[0..2]=0x13,0x002081B3,0x00F0C093 -> mem_addr 0,1,2 on consecutive cycles; if_pc 0,4,8 with matching if_instr, first if_valid 2 cycles after first mem_req.
REQ-035 stall=1 for 5 cycles while streaming -> mem_req drops once count+inflight=2; if_instr/if_pc constant; no instruction lost or duplicated after stall=0.
REQ-036 redirect=1, redirect_pc=0x0000_0010, same cycle as mem_valid -> response dropped; if_valid=0 next cycle; next mem_addr=4; next if_pc=0x10.
REQ-037 redirect and stall both 1 with full FIFO -> FIFO flushed, redirect honoured; redirect_pc=0x0000_0013 yields fetch at byte 0x10.
REQ-038 fetch_pc=0x0000_0FFC, ADDR_W=10 -> mem_addr 1023 then 0; if_pc 0xFFC then 0x1000.
REQ-039 rst_n pulsed low mid-stream with 2 entries buffered -> if_valid=0 within the same cycle; restart fetches from RESET_PC; with IFETCH_PERF_EN, counters read 0.

Source files
------------

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: fetch PC, one-outstanding-request credit logic, 2-entry {pc,instr} buffer.
// Define IFETCH_PERF_EN to add the perf_fetched / perf_stall counters.
module ifetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_valid,
  input  logic [31:0]       mem_instr,
  input  logic              stall,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic              if_valid,
  output logic [31:0]       if_instr,
  output logic [31:0]       if_pc,
`ifdef IFETCH_PERF_EN
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall,
`endif
  output logic [1:0]        dbg_state
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {S_WAIT, S_RUN, S_FULL, S_FLUSH} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        inflight_q, inflight_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] pc0_q, pc0_d, pc1_q, pc1_d;
  logic [31:0] ins0_q, ins0_d, ins1_q, ins1_d;

  logic       pop, push;
  logic [1:0] occ, occ_next, slot;

  // Handshake: a request in cycle N is answered by mem_valid in cycle N+1;
  // only answers to our own outstanding request are accepted.
  assign occ  = count_q + {1'b0, inflight_q};
  assign pop  = (count_q != 2'd0) && !stall && !redirect;
  assign push = mem_valid && inflight_q && !redirect;

  always_comb begin
    mem_req    = 1'b0;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = 1'b0;
    count_d    = count_q;
    pc0_d      = pc0_q;
    pc1_d      = pc1_q;
    ins0_d     = ins0_q;
    ins1_d     = ins1_q;
    slot       = count_q - {1'b0, pop};
    occ_next   = 2'd0;
    state_d    = state_q;

    if (state_q == S_RUN && !redirect && occ < 2'd2) mem_req = 1'b1;

    if (redirect) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      count_d    = 2'd0;
    end else begin
      if (mem_req) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        req_pc_d   = fetch_pc_q;
        inflight_d = 1'b1;
      end
      if (pop) begin
        pc0_d  = pc1_q;
        ins0_d = ins1_q;
      end
      if (push) begin
        if (slot == 2'd0) begin
          pc0_d  = req_pc_q;
          ins0_d = mem_instr;
        end else begin
          pc1_d  = req_pc_q;
          ins1_d = mem_instr;
        end
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    occ_next = count_d + {1'b0, inflight_d};

    case (state_q)
      S_WAIT:  state_d = S_RUN;
      S_RUN:   state_d = redirect ? S_FLUSH : ((occ_next == 2'd2) ? S_FULL : S_RUN);
      S_FULL:  state_d = redirect ? S_FLUSH : (pop ? S_RUN : S_FULL);
      S_FLUSH: state_d = redirect ? S_FLUSH : S_RUN;
      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_WAIT;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      inflight_q <= 1'b0;
      count_q    <= 2'd0;
      pc0_q      <= RESET_PC;
      pc1_q      <= RESET_PC;
      ins0_q     <= NOP;
      ins1_q     <= NOP;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      pc0_q      <= pc0_d;
      pc1_q      <= pc1_d;
      ins0_q     <= ins0_d;
      ins1_q     <= ins1_d;
    end
  end

  assign mem_addr  = fetch_pc_q[ADDR_W+1:2];
  assign if_valid  = (count_q != 2'd0);
  assign if_instr  = ins0_q;
  assign if_pc     = pc0_q;
  assign dbg_state = state_q;

`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= 32'd0;
      perf_stall_q   <= 32'd0;
    end else begin
      if (pop)               perf_fetched_q <= perf_fetched_q + 32'd1;
      if (if_valid && stall) perf_stall_q   <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule
